// File: rtl/hack_pc.sv
`default_nettype none
// ============================================================================
//  Module   : hack_pc
//  Purpose  : Hack CPU program counter with built-in jump decode and
//             detection of the terminal jump-to-self idle loop.
//  Revision : 1.0  initial release
// ============================================================================
module hack_pc #(
    parameter int WIDTH      = 16,
    parameter int HALT_COUNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             jmp_en,
    input  logic [2:0]       jbits,
    input  logic             zr,
    input  logic             ng,
    output logic [WIDTH-1:0] out,
    output logic             halted
);

    localparam int                  c_cnt_w   = $clog2(HALT_COUNT + 1);
    localparam logic [c_cnt_w-1:0]  c_halt    = c_cnt_w'(HALT_COUNT);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]    c_pc_one  = WIDTH'(1);

    logic [WIDTH-1:0]   r_out;
    logic               r_halted;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_jump_taken;
    logic               w_load_eff;
    logic               w_self_jump;
    logic               w_pc_moves;
    logic [c_cnt_w-1:0] w_cnt_next;

    // {j1,j2,j3} select the lt / eq / gt relations of the ALU result.
    assign w_jump_taken = jmp_en & ((jbits[2] & ng) |
                                    (jbits[1] & zr) |
                                    (jbits[0] & ~ng & ~zr));
    assign w_load_eff   = load | w_jump_taken;
    assign w_self_jump  = w_load_eff & (in == r_out);
    assign w_pc_moves   = (w_load_eff & (in != r_out)) | (~w_load_eff & inc);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_self_jump) begin
            if (r_cnt != c_halt) begin
                w_cnt_next = r_cnt + c_cnt_one;
            end
        end else if (w_pc_moves) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= '0;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_load_eff) begin
                r_out <= in;
            end else if (inc) begin
                r_out <= r_out + c_pc_one;
            end
            r_cnt    <= w_cnt_next;
            r_halted <= (w_cnt_next == c_halt);
        end
    end

    assign out    = r_out;
    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_hack_pc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hack_pc
//  Purpose  : Scoreboard testbench for hack_pc: directed scenarios followed
//             by randomized traffic against an abstract PC model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hack_pc;

    localparam int c_halt_count = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic        halted;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        jmp_en;
    logic [2:0]  jbits;
    logic        zr;
    logic        ng;
    logic [15:0] out;
    logic        halted;

    exp_t q_exp[$];
    int   n_cmp;
    int   n_err;
    int   m_pc;
    int   m_cnt;

    hack_pc #(.WIDTH(16), .HALT_COUNT(c_halt_count)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .load   (load),
        .inc    (inc),
        .jmp_en (jmp_en),
        .jbits  (jbits),
        .zr     (zr),
        .ng     (ng),
        .out    (out),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and push the model's view of the next PC state.
    task automatic step(input bit r, input bit ld, input bit ic, input bit je,
                        input bit [2:0] jb, input bit z, input bit n,
                        input bit [15:0] a);
        bit   lt, eq, gt, taken;
        exp_t e;
        @(negedge clk);
        reset = r; load = ld; inc = ic; jmp_en = je; jbits = jb;
        zr = z; ng = n; in = a;
        lt    = n;
        eq    = z;
        gt    = !n && !z;
        taken = je && ((jb[2] && lt) || (jb[1] && eq) || (jb[0] && gt));
        if (r) begin
            m_pc  = 0;
            m_cnt = 0;
        end else if (ld || taken) begin
            if (int'(a) == m_pc) m_cnt = (m_cnt + 1 > c_halt_count) ? c_halt_count : m_cnt + 1;
            else                 m_cnt = 0;
            m_pc = int'(a);
        end else if (ic) begin
            m_pc  = (m_pc + 1) % 65536;
            m_cnt = 0;
        end
        e.pc     = m_pc[15:0];
        e.halted = (m_cnt == c_halt_count);
        q_exp.push_back(e);
    endtask

    // Monitor: the PC presents a new value after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_cmp++;
                if (out !== e.pc || halted !== e.halted) begin
                    n_err++;
                    $display("FAIL pc_state @%0t: got out=%h halted=%b, expected out=%h halted=%b",
                             $time, out, halted, e.pc, e.halted);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit [15:0] a;
        bit        z, n;
        n_cmp = 0; n_err = 0; m_pc = 0; m_cnt = 0;
        reset = 1'b1; load = 1'b0; inc = 1'b0; jmp_en = 1'b0;
        jbits = 3'b000; zr = 1'b0; ng = 1'b0; in = '0;

        // Reset dominates load and inc, then count up.
        step(1, 1, 1, 0, 3'b000, 0, 0, 16'h1234);
        repeat (3) step(0, 0, 1, 0, 3'b000, 0, 0, 16'h0000);

        // Wrap and priority.
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'hFFFF);
        step(0, 0, 1, 0, 3'b000, 0, 0, 16'h0000);
        step(0, 1, 1, 0, 3'b000, 0, 0, 16'h00AA);
        step(0, 0, 0, 0, 3'b000, 0, 0, 16'h5555);

        // Jump decode from 0x0010 toward 0x0040 with inc as fallback.
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0010);
        step(0, 0, 1, 1, 3'b001, 0, 0, 16'h0040);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0010);
        step(0, 0, 1, 1, 3'b001, 0, 1, 16'h0040);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0010);
        step(0, 0, 1, 1, 3'b010, 1, 0, 16'h0040);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0010);
        step(0, 0, 1, 1, 3'b100, 0, 1, 16'h0040);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0010);
        step(0, 0, 1, 1, 3'b000, 1, 0, 16'h0040);
        step(0, 0, 1, 0, 3'b111, 0, 0, 16'h0040);
        step(0, 0, 0, 1, 3'b111, 0, 1, 16'h0077);

        // Self-loop detection.
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0020);
        repeat (3) step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0020);
        step(0, 0, 1, 0, 3'b000, 0, 0, 16'h0000);

        // Hold keeps the count; inc clears it.
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0030);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0030);
        step(0, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0030);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0050);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0050);
        step(0, 0, 1, 0, 3'b000, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0051);

        // Reset while halted.
        repeat (3) step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0060);
        step(1, 0, 0, 0, 3'b000, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 3'b000, 0, 0, 16'h0000);

        // Randomized traffic biased toward self-jumps and branch decode.
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 2) == 0) ? m_pc[15:0] : 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
            case ($urandom_range(0, 2))
                0: begin z = 1'b1; n = 1'b0; end
                1: begin z = 1'b0; n = 1'b1; end
                default: begin z = 1'b0; n = 1'b0; end
            endcase
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 3'($urandom), z, n, a);
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
